ddr_512b_pkt_gen: RTL and testbench
===================================

# ddr_512b_pkt_gen

Synthetic packet generator for the 512-bit DDR data path. It emits framed packets in the format the 512-bit DDR checker consumes: one encoder header beat, N ADC payload beats, and one end-flag beat. The generator sits at the head of the DDR write path in test mode, and the checker's success and error counters validate the full round trip. A single-shot error-injection input lets the bench prove that the checker's error counter works.

## Interface
Parameters:
- DATA_WD, 512: stream width; fixed, 32 lanes × 16 bit.
- HEAD_WD, 64: encoder header width.

Ports:
- clk, in, 1: sole clock.
- rst_n, in, 1: reset, synchronous, active-low.
- cfg_rst, in, 1: synchronous soft clear; same effect as rst_n.
- cfg_en, in, 1: level; run generator.
- cfg_pkt_beats, in, 16: payload beats per packet; 0 treated as 1.
- cfg_gap, in, 8: idle cycles between packets.
- cfg_pkt_num, in, 16: packets per run; 0 = unlimited.
- cfg_err_inj, in, 1: pulse; corrupt the next payload beat.
- m_axis_tdata, out, 512: stream data.
- m_axis_tvalid, out, 1: stream valid.
- m_axis_tlast, out, 1: high on the end-flag beat.
- m_axis_tready, in, 1: downstream ready.
- pkt_cnt, out, 32: packets completed since reset.
- busy, out, 1: high whenever state ≠ IDLE.

## Operation
- States are IDLE, HEAD, DATA, TAIL, GAP.
- IDLE → HEAD when cfg_en=1.
  - cfg_pkt_beats, cfg_gap and cfg_pkt_num are latched on this transition.
  - The run packet counter clears on this transition.
- HEAD beat:
  - tdata[63:0] = enc_cnt.
  - tdata[511:64] = 0.
  - On handshake: go to DATA and increment enc_cnt.
  - If the incremented value equals 64'h5A5ADEAD_0000FFFF, add 2 instead.
- DATA beat: lane i (tdata[16i+15:16i]) = adc_cnt + i, modulo 2^16.
  - On handshake: adc_cnt += 32 (wraps at 16 bits) and the beat counter increments.
  - After the latched beat count is reached: go to TAIL.
- TAIL beat:
  - tdata = {4{128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF}}.
  - tlast = 1.
  - On handshake: pkt_cnt += 1 (wraps), run counter += 1.
  - Then go to GAP if cfg_gap > 0, else straight to the next-state decision.
- GAP: counts cfg_gap cycles with tvalid=0, then goes to the next-state decision.
- Next-state decision:
  - IDLE if cfg_en=0 or the run counter equals a nonzero cfg_pkt_num.
  - Otherwise HEAD.
- cfg_en deasserted mid-packet: the current packet completes through TAIL and GAP, then IDLE. A packet is never truncated.
- Payload can never match the end flag in any 128-bit quarter, because quarter lanes are consecutive increments. The checker's end-flag exclusion is therefore exact.
- Error injection:
  - A cfg_err_inj pulse sets a sticky pending flag.
  - The next DATA beat is sent with bit 0 of lane 0 inverted.
  - The flag clears on that beat's handshake.
  - adc_cnt advances normally, so exactly one beat is wrong.
  - A pulse arriving while the flag is already pending is ignored.
- enc_cnt and adc_cnt persist across runs and clear only on reset or cfg_rst.

## Timing
- Reset (rst_n=0 or cfg_rst=1, sampled at clk edge) forces:
  - state = IDLE;
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0;
  - pkt_cnt = 0, busy = 0;
  - enc_cnt = 0, adc_cnt = 0;
  - error-injection flag cleared.
- A reset mid-packet abandons the packet immediately; no TAIL is emitted.
- All outputs are registered.
- First tvalid appears on the cycle after cfg_en is first sampled high in IDLE.
- AXIS rules:
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - tvalid does not depend on tready.
- Full throughput: with tready=1 and cfg_gap=0, one packet takes cfg_pkt_beats+2 cycles with no bubbles, including back-to-back packets.
- Gap length is exactly cfg_gap cycles of tvalid=0 between a TAIL handshake and the next HEAD beat.
- cfg_err_inj coinciding with a DATA handshake corrupts the following DATA beat, not the current one.

## Test plan
- Single packet:
  - Stimulus: beats=4, gap=0, num=1, cfg_en pulsed, tready=1.
  - Response: 6 beats total.
    - Header: tdata[63:0]=0.
    - Payload beat k: lane 0 = 32k; beat 3 lane 31 = 127.
    - TAIL with tlast=1.
  - After the run: pkt_cnt=1, busy=0; checker adc_suc=4, enc_suc=1, error counts 0.
- Back-to-back packets:
  - Stimulus: num=3, beats=2, gap=0.
  - Response: 12 consecutive valid cycles; header values 0, 1, 2; payload continues from 64 into packet 2.
- Backpressure:
  - Stimulus: tready toggled at random, 50%.
  - Response: each beat held stable until its handshake; sequence identical to the tready=1 run.
- Error injection:
  - Stimulus: cfg_err_inj during packet 1 of a continuous run.
  - Response: exactly one beat has lane-0 bit 0 flipped; checker err_cnt=1; later beats error-free.
- Stop and gap:
  - Stimulus: cfg_en dropped during DATA with gap=5.
  - Response: packet completes with TAIL, 5 idle cycles follow, then IDLE with busy=0.
- Mid-packet reset:
  - Stimulus: rst_n=0 for one cycle mid-DATA.
  - Response: tvalid=0 the next cycle; enc_cnt and adc_cnt return to 0.

Source files
------------

// File: rtl/ddr_512b_pkt_gen.sv
// Framed packet source for the 512-bit DDR path: encoder header, ADC ramp payload, end-flag beat.
// Drives a registered AXIS master. A one-shot error injection corrupts a single payload beat.

module ddr_512b_pkt_gen_lane #(
    parameter int IDX = 0
) (
    input  logic [15:0] base,
    output logic [15:0] val
);
    assign val = base + 16'(IDX);
endmodule

module ddr_512b_pkt_gen #(
    parameter int DATA_WD = 512,
    parameter int HEAD_WD = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_rst,
    input  logic               cfg_en,
    input  logic [15:0]        cfg_pkt_beats,
    input  logic [7:0]         cfg_gap,
    input  logic [15:0]        cfg_pkt_num,
    input  logic               cfg_err_inj,
    output logic [DATA_WD-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready,
    output logic [31:0]        pkt_cnt,
    output logic               busy
);
    localparam int NUM_LANES = DATA_WD / 16;
    localparam logic [63:0] END_WORD = 64'h5A5ADEAD_0000FFFF;
    localparam logic [HEAD_WD-1:0] ENC_SKIP = HEAD_WD'(64'h5A5ADEAD_0000FFFF);

    typedef enum logic [2:0] {IDLE, HEAD, DATA, TAIL, GAP} state_t;

    state_t              state, state_n;
    logic [15:0]         beats_lat, num_lat, run_cnt, run_n, beat_cnt, beat_n;
    logic [7:0]          gap_lat, gap_cnt, gap_n;
    logic [HEAD_WD-1:0]  enc_cnt, enc_n, enc_step;
    logic [15:0]         adc_cnt, adc_n;
    logic [31:0]         pkt_n;
    logic                err_pend, err_pend_n, cur_bad, cur_bad_n;
    logic                latch, hs, load, flip, srst;
    logic [DATA_WD-1:0]  tdata_n;
    logic                tvalid_n, tlast_n;
    logic [NUM_LANES-1:0][15:0] lanes;

    assign srst = ~rst_n | cfg_rst;
    assign hs   = m_axis_tvalid & m_axis_tready;
    // The output register is free for a new beat when empty or being consumed.
    assign load = ~m_axis_tvalid | hs;
    assign enc_step = (enc_cnt + HEAD_WD'(1) == ENC_SKIP) ? enc_cnt + HEAD_WD'(2)
                                                         : enc_cnt + HEAD_WD'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            ddr_512b_pkt_gen_lane #(.IDX(gi)) u_lane (.base(adc_n), .val(lanes[gi]));
        end
    endgenerate

    always_comb begin
        state_n = state;
        enc_n   = enc_cnt;
        adc_n   = adc_cnt;
        beat_n  = beat_cnt;
        gap_n   = gap_cnt;
        run_n   = run_cnt;
        pkt_n   = pkt_cnt;
        latch   = 1'b0;
        case (state)
            IDLE: if (cfg_en) begin
                state_n = HEAD;
                latch   = 1'b1;
                run_n   = 16'd0;
            end
            HEAD: if (hs) begin
                state_n = DATA;
                enc_n   = enc_step;
                beat_n  = 16'd0;
            end
            DATA: if (hs) begin
                adc_n  = adc_cnt + 16'd32;
                beat_n = beat_cnt + 16'd1;
                if (beat_cnt + 16'd1 == beats_lat) state_n = TAIL;
            end
            TAIL: if (hs) begin
                pkt_n = pkt_cnt + 32'd1;
                run_n = run_cnt + 16'd1;
                gap_n = 8'd0;
                if (gap_lat != 8'd0)
                    state_n = GAP;
                else if (!cfg_en || (num_lat != 16'd0 && run_cnt + 16'd1 == num_lat))
                    state_n = IDLE;
                else
                    state_n = HEAD;
            end
            GAP: begin
                gap_n = gap_cnt + 8'd1;
                if (gap_cnt == gap_lat - 8'd1)
                    state_n = (!cfg_en || (num_lat != 16'd0 && run_cnt == num_lat)) ? IDLE : HEAD;
            end
            default: state_n = IDLE;
        endcase
    end

    // A pending injection lands on the next payload beat loaded after it was sampled,
    // never on the beat whose handshake clears it.
    always_comb begin
        err_pend_n = (err_pend & ~(hs & cur_bad)) | (cfg_err_inj & ~err_pend);
        flip       = err_pend & ~(hs & cur_bad);
        tdata_n    = m_axis_tdata;
        tvalid_n   = m_axis_tvalid;
        tlast_n    = m_axis_tlast;
        cur_bad_n  = cur_bad;
        if (load) begin
            tdata_n   = '0;
            tvalid_n  = 1'b0;
            tlast_n   = 1'b0;
            cur_bad_n = 1'b0;
            case (state_n)
                HEAD: begin
                    tdata_n  = DATA_WD'(enc_n);
                    tvalid_n = 1'b1;
                end
                DATA: begin
                    tdata_n   = lanes ^ DATA_WD'(flip);
                    tvalid_n  = 1'b1;
                    cur_bad_n = flip;
                end
                TAIL: begin
                    tdata_n  = {(DATA_WD/64){END_WORD}};
                    tvalid_n = 1'b1;
                    tlast_n  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state         <= IDLE;
            beats_lat     <= 16'd1;
            gap_lat       <= 8'd0;
            num_lat       <= 16'd0;
            run_cnt       <= 16'd0;
            beat_cnt      <= 16'd0;
            gap_cnt       <= 8'd0;
            enc_cnt       <= '0;
            adc_cnt       <= 16'd0;
            pkt_cnt       <= 32'd0;
            err_pend      <= 1'b0;
            cur_bad       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state    <= state_n;
            run_cnt  <= run_n;
            beat_cnt <= beat_n;
            gap_cnt  <= gap_n;
            enc_cnt  <= enc_n;
            adc_cnt  <= adc_n;
            pkt_cnt  <= pkt_n;
            err_pend <= err_pend_n;
            cur_bad  <= cur_bad_n;
            if (latch) begin
                beats_lat <= (cfg_pkt_beats == 16'd0) ? 16'd1 : cfg_pkt_beats;
                gap_lat   <= cfg_gap;
                num_lat   <= cfg_pkt_num;
            end
            m_axis_tdata  <= tdata_n;
            m_axis_tvalid <= tvalid_n;
            m_axis_tlast  <= tlast_n;
            busy          <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_ddr_512b_pkt_gen.sv
// Directed/randomized bench for ddr_512b_pkt_gen against a packet-level stream model.
module tb_ddr_512b_pkt_gen;
    localparam logic [63:0]  MAGIC = 64'h5A5ADEAD_0000FFFF;
    localparam logic [511:0] TAILW = {4{128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF}};

    logic         clk = 1'b0;
    logic         rst_n, cfg_rst, cfg_en, cfg_err_inj, tready;
    logic [15:0]  cfg_pkt_beats, cfg_pkt_num;
    logic [7:0]   cfg_gap;
    logic [511:0] tdata;
    logic         tvalid, tlast, busy;
    logic [31:0]  pkt_cnt;

    always #5 clk = ~clk;

    ddr_512b_pkt_gen #(.DATA_WD(512), .HEAD_WD(64)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst), .cfg_en(cfg_en),
        .cfg_pkt_beats(cfg_pkt_beats), .cfg_gap(cfg_gap), .cfg_pkt_num(cfg_pkt_num),
        .cfg_err_inj(cfg_err_inj), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tlast(tlast), .m_axis_tready(tready), .pkt_cnt(pkt_cnt), .busy(busy)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [512:0] got[$];
    int           got_cyc[$];
    logic [512:0] exp_q[$];
    int           kind_q[$];
    logic [63:0]  m_enc;
    logic [15:0]  m_adc;
    int           m_pkt;

    task automatic check(input string tag, input logic [512:0] obs, input logic [512:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    // Monitor: sample mid-cycle, log handshakes, check AXIS hold rules.
    initial begin
        logic pv, pr, pl, prst;
        logic [511:0] pd;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; prst = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!prst && pv && !pr) begin
                check("hold_valid", 513'(tvalid), 513'(1));
                check("hold_beat", {tlast, tdata}, {pl, pd});
            end
            if (tvalid && tready) begin
                got.push_back({tlast, tdata});
                got_cyc.push_back(cyc);
            end
            pv = tvalid; pr = tready; pl = tlast; pd = tdata;
            prst = !rst_n || cfg_rst;
        end
    end

    function automatic logic [511:0] payload(input logic [15:0] a);
        logic [511:0] d;
        for (int i = 0; i < 32; i++) d[16*i +: 16] = a + 16'(i);
        return d;
    endfunction

    task automatic add_pkt(input int beats);
        int n;
        n = (beats == 0) ? 1 : beats;
        exp_q.push_back({1'b0, 448'd0, m_enc}); kind_q.push_back(0);
        m_enc = m_enc + 64'd1;
        if (m_enc == MAGIC) m_enc = m_enc + 64'd1;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({1'b0, payload(m_adc)}); kind_q.push_back(1);
            m_adc = m_adc + 16'd32;
        end
        exp_q.push_back({1'b1, TAILW}); kind_q.push_back(2);
        m_pkt++;
    endtask

    task automatic clear_q();
        got.delete(); got_cyc.delete(); exp_q.delete(); kind_q.delete();
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        check({tag, "_len"}, 513'(got.size()), 513'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
    endtask

    task automatic run_until(input int target, input bit rnd, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rnd) tready = 1'($urandom_range(0, 1));
            if (pkt_cnt == 32'(target)) begin
                cfg_en = 1'b0;
                done = 1'b1;
                break;
            end
        end
        check("run_timeout", 513'(done), 513'(1));
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin done = 1'b1; break; end
            tick();
        end
        tready = 1'b1;
        check("idle_timeout", 513'(done), 513'(1));
    endtask

    task automatic do_cfg_rst();
        tick(); cfg_rst = 1'b1; tick(); cfg_rst = 1'b0;
        m_enc = '0; m_adc = '0; m_pkt = 0;
        clear_q();
        @(negedge clk);
        check("cfg_rst_pkt", 513'(pkt_cnt), 513'(0));
    endtask

    initial begin
        int base, m, diffs;
        bit found;
        rst_n = 1'b0; cfg_rst = 1'b0; cfg_en = 1'b0; cfg_err_inj = 1'b0; tready = 1'b1;
        cfg_pkt_beats = 16'd4; cfg_gap = 8'd0; cfg_pkt_num = 16'd1;
        m_enc = '0; m_adc = '0; m_pkt = 0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_tvalid", 513'(tvalid), 513'(0));
        check("rst_tlast", 513'(tlast), 513'(0));
        check("rst_tdata", 513'(tdata), 513'(0));
        check("rst_pkt", 513'(pkt_cnt), 513'(0));
        check("rst_busy", 513'(busy), 513'(0));
        tick(); rst_n = 1'b1; tick();
        clear_q();

        // single packet, first-beat latency
        cfg_en = 1'b1;
        @(negedge clk);
        check("lat_pre", 513'(tvalid), 513'(0));
        tick(); cfg_en = 1'b0;
        @(negedge clk);
        check("lat_first", 513'(tvalid), 513'(1));
        add_pkt(4);
        run_until(1, 1'b0, 100);
        cmp_stream("single");
        if (got.size() > 4) check("b3_lane31", 513'(got[4][511:496]), 513'(127));
        check("single_pkt", 513'(pkt_cnt), 513'(1));
        check("single_busy", 513'(busy), 513'(0));

        // back-to-back packets, no bubbles
        do_cfg_rst();
        cfg_pkt_beats = 16'd2; cfg_gap = 8'd0; cfg_pkt_num = 16'd3; cfg_en = 1'b1;
        repeat (3) add_pkt(2);
        run_until(3, 1'b0, 200);
        cmp_stream("b2b");
        if (got_cyc.size() >= 12) check("b2b_span", 513'(got_cyc[11] - got_cyc[0]), 513'(11));

        // random backpressure
        do_cfg_rst();
        cfg_pkt_beats = 16'd3; cfg_gap = 8'd2; cfg_pkt_num = 16'd3; cfg_en = 1'b1;
        repeat (3) add_pkt(3);
        run_until(3, 1'b1, 2000);
        cmp_stream("bp");

        // error injection in packet 1 of a continuous run
        clear_q();
        base = m_pkt;
        cfg_pkt_beats = 16'd4; cfg_gap = 8'd0; cfg_pkt_num = 16'd3; cfg_en = 1'b1;
        repeat (3) tick();
        m = cyc + 1;
        cfg_err_inj = 1'b1;
        tick();
        cfg_err_inj = 1'b0;
        repeat (3) add_pkt(4);
        run_until(base + 3, 1'b0, 200);
        diffs = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) diffs++;
        check("err_one_beat", 513'(diffs), 513'(1));
        for (int i = 0; i < got_cyc.size() && i < exp_q.size(); i++)
            if (kind_q[i] == 1 && got_cyc[i] >= m + 2) begin
                exp_q[i][0] = ~exp_q[i][0];
                break;
            end
        cmp_stream("err");

        // stop mid-packet with gap
        clear_q();
        base = m_pkt;
        cfg_pkt_beats = 16'd6; cfg_gap = 8'd5; cfg_pkt_num = 16'd0; cfg_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pkt_cnt == 32'(base + 1)) begin found = 1'b1; break; end
        end
        check("stop_first", 513'(found), 513'(1));
        repeat (8) tick();
        cfg_en = 1'b0;
        repeat (2) add_pkt(6);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tvalid && tlast) begin found = 1'b1; break; end
        end
        check("stop_tail", 513'(found), 513'(1));
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            check($sformatf("gap_valid%0d", g), 513'(tvalid), 513'(0));
            check($sformatf("gap_busy%0d", g), 513'(busy), 513'(1));
        end
        @(negedge clk);
        check("stop_busy", 513'(busy), 513'(0));
        check("stop_valid", 513'(tvalid), 513'(0));
        cmp_stream("stop");
        if (got_cyc.size() > 8) check("gap_span", 513'(got_cyc[8] - got_cyc[7]), 513'(6));
        check("stop_pkt", 513'(pkt_cnt), 513'(base + 2));

        // mid-packet reset, then a beats=0 packet from cleared counters
        cfg_pkt_beats = 16'd8; cfg_gap = 8'd0; cfg_pkt_num = 16'd0; cfg_en = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0; cfg_en = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_valid", 513'(tvalid), 513'(0));
        check("mrst_busy", 513'(busy), 513'(0));
        check("mrst_pkt", 513'(pkt_cnt), 513'(0));
        clear_q();
        m_enc = '0; m_adc = '0; m_pkt = 0;
        cfg_pkt_beats = 16'd0; cfg_pkt_num = 16'd1; cfg_en = 1'b1;
        tick();
        cfg_en = 1'b0;
        add_pkt(0);
        run_until(1, 1'b0, 100);
        cmp_stream("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
